logic_op_sequencer: RTL and testbench
=====================================

// Module: logic_op_sequencer
// PURPOSE
//   Bit-serial logic-operation engine: accepts one request of two WIDTH-bit operands plus an opcode.
//   Evaluates one bit per cycle through a single shared 1-bit logic unit built from the existing
//   2-input gate primitives; returns the WIDTH-bit result over a valid/ready handshake.
//   Sits between a command source (CPU/test controller) and any consumer needing bitwise results at minimal area.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range 2..64
//   CNT_W   $clog2(WIDTH)   bit-index counter width (derived, not overridden)
// PORTS
//   clk        in   1       single clock, all state on rising edge
//   rst_n      in   1       synchronous, active-low reset
//   in_valid   in   1       request valid
//   in_ready   out  1       engine can accept request (high only in IDLE)
//   in_op      in   3       opcode: 0 AND, 1 OR, 2 NOT(a), 3 XOR, 4 NAND, 5 NOR, 6/7 illegal
//   in_a       in   WIDTH   operand A
//   in_b       in   WIDTH   operand B (ignored for NOT)
//   out_valid  out  1       result valid
//   out_ready  in   1       consumer accepts result
//   out_result out  WIDTH   result; bit i = op(a[i], b[i])
//   out_err    out  1       1 = illegal opcode, out_result forced to 0
//   busy       out  1       high in RUN or DONE
// BEHAVIOUR
//   Reset (rst_n low at a clk edge): state=IDLE, in_ready=1 after reset, out_valid=0, out_result=0,
//     out_err=0, busy=0, bit index=0, latched operands/op=0. Reset mid-RUN/DONE aborts; no out_valid.
//   FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1. Edge with in_valid&in_ready: latch a,b,op; clear out_result, idx=0.
//     Legal op -> RUN. Illegal op (6/7) -> DONE with out_err=1, out_result=0.
//   RUN: in_ready=0. Each edge: out_result[idx] <= unit(op,a[idx],b[idx]); idx++.
//     Edge at idx==WIDTH-1 -> DONE (idx returns to 0). LSB first.
//   DONE: out_valid=1; out_result/out_err held stable. Edge with out_ready -> IDLE, out_valid=0.
//     out_err cleared on the next accepted request.
//   Latency: legal op -> out_valid high exactly WIDTH cycles after the accept edge.
//     Illegal op -> out_valid high 1 cycle after the accept edge.
//   No overlap: request not accepted in the same cycle as the output handshake.
//     Earliest next accept is the edge after the return to IDLE. Throughput: 1 op / (WIDTH+2) cycles max.
//   in_* ignored when in_ready=0; out_ready ignored outside DONE.
//   Outputs all registered; no combinational path from in_* / out_ready to any output.
// STRUCTURE
//   Package logic_seq_pkg:
//     - opcode localparams OP_AND..OP_NOR
//     - state encoding ST_IDLE/ST_RUN/ST_DONE (2-bit)
//     - function op_is_legal(op)
//   Sub-module bit_logic_unit: combinational, inputs op[2:0], a, b; output y.
//     - instantiates one each of and/or/not/xor/nand/nor gate primitives and muxes by op.
//     - y=0 for illegal op.
//   Top module: FSM, index counter, operand/op registers, result register, handshake.
// TESTING (WIDTH=8)
//   AND a=8'hF0 b=8'h3C:
//     -> out_result=8'h30, out_err=0; out_valid rises 8 cycles after accept.
//   NOR a=8'h00 b=8'h0F -> 8'hF0; then NAND a=8'hFF b=8'hFF -> 8'h00.
//     XOR a=8'hAA b=8'hFF -> 8'h55; OR a=8'h81 b=8'h18 -> 8'h99.
//   NOT a=8'hA5 b=8'hFF -> out_result=8'h5A (b ignored).
//   op=3'd7 a=8'hFF b=8'hFF -> out_err=1, out_result=8'h00; out_valid 1 cycle after accept.
//   Backpressure: hold out_ready=0 for 5 cycles in DONE.
//     -> out_result/out_err stable, in_ready=0, in_valid held high not accepted.
//     -> accept occurs on the edge after the out handshake returns to IDLE.
//   Reset: drive rst_n=0 for 1 edge while RUN at idx=3.
//     -> all outputs at reset values next cycle, no out_valid.
//     -> following AND 8'h0F,8'hFF completes with 8'h0F.

Source files
------------

// File: rtl/logic_op_sequencer_pkg.sv
// Shared definitions for the bit-serial logic-operation engine:
// opcode values, FSM state encoding and opcode legality check.
package logic_seq_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Opcodes 6 and 7 are reserved and reported as errors.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_NOR);
    endfunction

endpackage

// File: rtl/logic_op_sequencer_if.sv
// Request/response bundle between a command source (master) and the
// logic-operation engine (slave).
interface logic_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_err;
    logic             busy;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_err, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_err, busy
    );
endinterface

// File: rtl/logic_op_sequencer_bit_logic_unit.sv
// Single shared 1-bit logic unit: one instance of each 2-input gate
// primitive, with the opcode selecting which gate drives the output.
module bit_logic_unit
    import logic_seq_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic       a_i,
    input  logic       b_i,
    output logic       y_o
);
    logic y_and;
    logic y_or;
    logic y_not;
    logic y_xor;
    logic y_nand;
    logic y_nor;

    and  u_and  (y_and,  a_i, b_i);
    or   u_or   (y_or,   a_i, b_i);
    not  u_not  (y_not,  a_i);
    xor  u_xor  (y_xor,  a_i, b_i);
    nand u_nand (y_nand, a_i, b_i);
    nor  u_nor  (y_nor,  a_i, b_i);

    // Opcode mux; reserved opcodes yield 0.
    always_comb begin
        y_o = 1'b0;
        case (op_i)
            OP_AND:  y_o = y_and;
            OP_OR:   y_o = y_or;
            OP_NOT:  y_o = y_not;
            OP_XOR:  y_o = y_xor;
            OP_NAND: y_o = y_nand;
            OP_NOR:  y_o = y_nor;
            default: y_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/logic_op_sequencer.sv
// Bit-serial logic-operation engine. Accepts one request at a time,
// evaluates one result bit per cycle (LSB first) through a single
// shared bit_logic_unit and presents the result until it is consumed.
// Every output is driven straight from a register.
module logic_op_sequencer
    import logic_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    logic_op_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic             err_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             res_bit_d;

    bit_logic_unit u_unit (
        .op_i (op_q),
        .a_i  (a_q[idx_q]),
        .b_i  (b_q[idx_q]),
        .y_o  (res_bit_d)
    );

    // Control FSM, index counter, operand latches and result shift-in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.in_a;
                        b_q        <= bus.in_b;
                        op_q       <= bus.in_op;
                        result_q   <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (op_is_legal(bus.in_op)) begin
                            err_q   <= 1'b0;
                            state_q <= ST_RUN;
                        end else begin
                            // Reserved opcode: skip evaluation, report at once.
                            err_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    result_q[idx_q] <= res_bit_d;
                    if (idx_q == IDX_LAST) begin
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // Ready returns only after this edge, so no accept can
                    // coincide with the output handshake.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.out_err    = err_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_logic_op_sequencer.sv
// Randomized self-checking bench for logic_op_sequencer (WIDTH=8).
module tb_logic_op_sequencer;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic_op_sequencer_if #(.WIDTH(W)) bus ();

    logic_op_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: bitwise result of the whole word; reserved opcodes give 0.
    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return a ^ b;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            default: return '0;
        endcase
    endfunction

    task automatic drive_junk();
        bus.in_op = 3'($urandom);
        bus.in_a  = W'($urandom);
        bus.in_b  = W'($urandom);
    endtask

    // One complete transaction. pre=1: request already on the bus at this
    // negedge. chain=1: during DONE keep in_valid high carrying the next
    // request (nop/na/nb), which must only be taken after return to IDLE.
    task automatic do_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input int hold, input bit pre,
                          input bit chain, input logic [2:0] nop,
                          input logic [W-1:0] na, input logic [W-1:0] nb);
        int   w;
        int   lat;
        logic exp_err;
        exp_err = (op > 3'd5);
        if (!pre) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_op    = op;
            bus.in_a     = a;
            bus.in_b     = b;
        end
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", 64'(w), 64'd0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'($urandom_range(0, 1));
        drive_junk();
        chk("run_in_ready", 64'(bus.in_ready), 64'd0);
        chk("run_busy", 64'(bus.busy), 64'd1);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = 1'($urandom_range(0, 1));
            drive_junk();
            @(negedge clk);
            lat++;
        end
        // Legal ops: valid W edges after the accept edge; reserved ops:
        // valid already in the cycle right after the accept edge.
        chk("latency", 64'(lat), exp_err ? 64'd0 : 64'(W));
        chk("result", 64'(bus.out_result), 64'(exp_res));
        chk("err", 64'(bus.out_err), 64'(exp_err));
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            if (chain) begin
                bus.in_valid = 1'b1;
                bus.in_op    = nop;
                bus.in_a     = na;
                bus.in_b     = nb;
            end else begin
                bus.in_valid = 1'($urandom_range(0, 1));
                drive_junk();
            end
            @(negedge clk);
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_result", 64'(bus.out_result), 64'(exp_res));
            chk("hold_err", 64'(bus.out_err), 64'(exp_err));
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        if (chain) begin
            bus.in_valid = 1'b1;
            bus.in_op    = nop;
            bus.in_a     = na;
            bus.in_b     = nb;
        end else begin
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("hs_valid", 64'(bus.out_valid), 64'd0);
        chk("hs_in_ready", 64'(bus.in_ready), 64'd1);
        chk("hs_busy", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [2:0]   op_c, op_n;
        logic [W-1:0] a_c, b_c, a_n, b_n;
        bit           pre_c, chain_c;
        bit           seen_valid;
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(bus.out_result), 64'd0);
        chk("rst_err", 64'(bus.out_err), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);

        // Directed cases with fixed expected words.
        do_req(3'd0, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        do_req(3'd5, 8'h00, 8'h0F, 8'hF0, 1, 0, 0, 3'd0, 8'h00, 8'h00);
        do_req(3'd4, 8'hFF, 8'hFF, 8'h00, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        do_req(3'd3, 8'hAA, 8'hFF, 8'h55, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        do_req(3'd1, 8'h81, 8'h18, 8'h99, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        do_req(3'd2, 8'hA5, 8'hFF, 8'h5A, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        do_req(3'd7, 8'hFF, 8'hFF, 8'h00, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        do_req(3'd6, 8'h12, 8'h34, 8'h00, 0, 0, 0, 3'd0, 8'h00, 8'h00);
        // Backpressure for 5 cycles with the next request pending, then
        // that request is taken on the first edge back in IDLE.
        do_req(3'd3, 8'h3C, 8'h0F, 8'h33, 5, 0, 1, 3'd0, 8'hC3, 8'h5A);
        do_req(3'd0, 8'hC3, 8'h5A, 8'h42, 0, 1, 0, 3'd0, 8'h00, 8'h00);

        // Reset while RUN with three bits already processed.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd1;
        bus.in_a     = 8'h3C;
        bus.in_b     = 8'hC3;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_result", 64'(bus.out_result), 64'd0);
        chk("mid_rst_err", 64'(bus.out_err), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        seen_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (W + 2) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid = 1'b1;
        end
        bus.out_ready = 1'b0;
        chk("mid_rst_no_valid", 64'(seen_valid), 64'd0);
        do_req(3'd0, 8'h0F, 8'hFF, 8'h0F, 0, 0, 0, 3'd0, 8'h00, 8'h00);

        // Randomized traffic against the reference model.
        op_n  = 3'($urandom_range(0, 7));
        a_n   = W'($urandom);
        b_n   = W'($urandom);
        pre_c = 1'b0;
        for (int t = 0; t < 40; t++) begin
            op_c    = op_n;
            a_c     = a_n;
            b_c     = b_n;
            op_n    = 3'($urandom_range(0, 7));
            a_n     = W'($urandom);
            b_n     = W'($urandom);
            chain_c = 1'($urandom_range(0, 1));
            do_req(op_c, a_c, b_c, model(op_c, a_c, b_c), int'($urandom_range(0, 3)),
                   pre_c, chain_c, op_n, a_n, b_n);
            pre_c = chain_c;
        end
        if (pre_c) begin
            do_req(op_n, a_n, b_n, model(op_n, a_n, b_n), 0, 1, 0, 3'd0, 8'h00, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
